// File: rtl/riscv_profiler_pkg.sv
// Purpose: shared types, RV32 opcodes and the power-up class table for the instruction-class profiler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_profiler_pkg;

    localparam logic [6:0] OPCODE_LOAD   = 7'h03;
    localparam logic [6:0] OPCODE_OPIMM  = 7'h13;
    localparam logic [6:0] OPCODE_STORE  = 7'h23;
    localparam logic [6:0] OPCODE_OP     = 7'h33;
    localparam logic [6:0] OPCODE_OP_FP  = 7'h53;
    localparam logic [6:0] OPCODE_BRANCH = 7'h63;
    localparam logic [6:0] OPCODE_JALR   = 7'h67;
    localparam logic [6:0] OPCODE_JAL    = 7'h6F;
    localparam logic [6:0] OPCODE_SYSTEM = 7'h73;

    localparam int DEFAULT_ENTRIES = 8;

    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] match;
        logic        en;
    } prof_entry_t;

    // ALU: bit 5 is masked out so OPCODE_OP and OPCODE_OPIMM share one entry.
    // JAL/JALR: bit 3 is the only difference between the two opcodes.
    // MULDIV sits behind ALU, so it only counts once entry 0 is disabled or reprogrammed.
    localparam prof_entry_t DEFAULT_TABLE [DEFAULT_ENTRIES] = '{
        '{32'h0000_005F, {25'd0, OPCODE_OPIMM}, 1'b1},
        '{32'h0000_007F, {25'd0, OPCODE_BRANCH}, 1'b1},
        '{32'h0000_0077, {25'd0, OPCODE_JALR}, 1'b1},
        '{32'h0000_007F, {25'd0, OPCODE_LOAD}, 1'b1},
        '{32'h0000_007F, {25'd0, OPCODE_STORE}, 1'b1},
        '{{7'h7F, 18'd0, 7'h7F}, {7'b0000001, 18'd0, OPCODE_OP}, 1'b1},
        '{32'h0000_007F, {25'd0, OPCODE_OP_FP}, 1'b1},
        '{32'h0000_007F, {25'd0, OPCODE_SYSTEM}, 1'b1}
    };

    // Reset value of table entry idx; entries beyond the default set come up disabled.
    function automatic prof_entry_t default_entry(input int idx);
        prof_entry_t e;
        e = '0;
        if (idx >= 0 && idx < DEFAULT_ENTRIES) begin
            e = DEFAULT_TABLE[idx[2:0]];
        end
        return e;
    endfunction

endpackage

// File: rtl/riscv_instr_class_profiler_if.sv
// Purpose: retire, table-config and counter-read signals of the profiler bundled into one interface.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a single-cycle strobe or level.
interface riscv_instr_class_profiler_if #(
    parameter int NUM_CLASSES = 8,
    parameter int CNT_WIDTH   = 32
);
    localparam int IDX_W = $clog2(NUM_CLASSES + 1);

    logic                   en_i;
    logic                   ret_valid_i;
    logic [31:0]            ret_instr_i;
    logic                   cfg_we_i;
    logic [IDX_W-1:0]       cfg_idx_i;
    logic [31:0]            cfg_mask_i;
    logic [31:0]            cfg_match_i;
    logic                   cfg_en_i;
    logic                   rd_req_i;
    logic [IDX_W-1:0]       rd_idx_i;
    logic                   rd_clr_i;
    logic                   rd_valid_o;
    logic [CNT_WIDTH-1:0]   rd_data_o;
    logic [NUM_CLASSES:0]   ovf_o;

    modport master (
        output en_i, ret_valid_i, ret_instr_i,
        output cfg_we_i, cfg_idx_i, cfg_mask_i, cfg_match_i, cfg_en_i,
        output rd_req_i, rd_idx_i, rd_clr_i,
        input  rd_valid_o, rd_data_o, ovf_o
    );

    modport slave (
        input  en_i, ret_valid_i, ret_instr_i,
        input  cfg_we_i, cfg_idx_i, cfg_mask_i, cfg_match_i, cfg_en_i,
        input  rd_req_i, rd_idx_i, rd_clr_i,
        output rd_valid_o, rd_data_o, ovf_o
    );

endinterface

// File: rtl/riscv_instr_class_profiler_match.sv
// Purpose: classify one instruction word against a {mask,match,en} table; lowest enabled hit wins.
// Latency: combinational.
// Backpressure: none.
module riscv_prof_match
    import riscv_profiler_pkg::*;
#(
    parameter  int NUM_CLASSES = 8,
    localparam int IDX_W       = $clog2(NUM_CLASSES + 1)
) (
    input  logic [31:0]      instr,
    input  prof_entry_t      tbl [NUM_CLASSES],
    output logic             hit_any,
    output logic [IDX_W-1:0] cls
);

    // Scan from the top entry down so the lowest matching index is the last one written.
    // cls is 0 when nothing hits; callers decide what a miss maps to.
    always_comb begin
        hit_any = 1'b0;
        cls     = '0;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (tbl[i].en && ((instr & tbl[i].mask) == tbl[i].match)) begin
                hit_any = 1'b1;
                cls     = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/riscv_instr_class_profiler.sv
// Purpose: count retired instructions per programmable class (plus OTHER), readable with optional clear.
// Latency: retire to visible count 3 cycles; read request to rd_valid/rd_data 1 cycle.
// Backpressure: none; accepts one retire per cycle, counters saturate instead of stalling.
module riscv_instr_class_profiler
    import riscv_profiler_pkg::*;
#(
    parameter int NUM_CLASSES = 8,
    parameter int CNT_WIDTH   = 32
) (
    input logic                          clk,
    input logic                          rst,
    riscv_instr_class_profiler_if.slave  bus
);

    localparam int               IDX_W     = $clog2(NUM_CLASSES + 1);
    localparam int               NUM_CNT   = NUM_CLASSES + 1;
    localparam logic [IDX_W-1:0] OTHER_IDX = IDX_W'(NUM_CLASSES);

    prof_entry_t          tbl_q [NUM_CLASSES];
    logic                 s0_vld;
    logic [31:0]          s0_instr;
    logic                 s1_vld;
    logic [IDX_W-1:0]     s1_cls;
    logic                 hit_any;
    logic [IDX_W-1:0]     hit_cls;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf_q;
    logic [NUM_CNT-1:0]   inc_vec;
    logic [NUM_CNT-1:0]   clr_vec;
    logic [CNT_WIDTH-1:0] rd_mux;
    logic                 rd_valid_q;
    logic [CNT_WIDTH-1:0] rd_data_q;

    // Class table: defaults on reset, single-entry writes land at the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                tbl_q[i] <= default_entry(i);
            end
        end else begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (bus.cfg_we_i && (bus.cfg_idx_i == IDX_W'(i))) begin
                    tbl_q[i] <= '{bus.cfg_mask_i, bus.cfg_match_i, bus.cfg_en_i};
                end
            end
        end
    end

    riscv_prof_match #(
        .NUM_CLASSES (NUM_CLASSES)
    ) u_match (
        .instr   (s0_instr),
        .tbl     (tbl_q),
        .hit_any (hit_any),
        .cls     (hit_cls)
    );

    // S0 captures the retire port, S1 captures the class chosen against the live table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld   <= 1'b0;
            s0_instr <= '0;
            s1_vld   <= 1'b0;
            s1_cls   <= '0;
        end else begin
            s0_vld   <= bus.ret_valid_i;
            s0_instr <= bus.ret_instr_i;
            s1_vld   <= s0_vld;
            s1_cls   <= hit_any ? hit_cls : OTHER_IDX;
        end
    end

    // Per-counter increment/clear strobes and the read mux; out-of-range read indices select nothing.
    always_comb begin
        inc_vec = '0;
        clr_vec = '0;
        rd_mux  = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            inc_vec[i] = s1_vld && bus.en_i && (s1_cls == IDX_W'(i));
            clr_vec[i] = bus.rd_req_i && bus.rd_clr_i && (bus.rd_idx_i == IDX_W'(i));
            if (bus.rd_idx_i == IDX_W'(i)) begin
                rd_mux = cnt_q[i];
            end
        end
    end

    // S2 counters: saturate at all-ones with a sticky flag; a clear racing an increment keeps that event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (clr_vec[i]) begin
                    cnt_q[i] <= inc_vec[i] ? CNT_WIDTH'(1) : '0;
                    ovf_q[i] <= 1'b0;
                end else if (inc_vec[i]) begin
                    if (&cnt_q[i]) begin
                        ovf_q[i] <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Read port: pulse valid for one cycle, data holds the pre-edge counter value until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_req_i;
            if (bus.rd_req_i) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = rd_data_q;
    assign bus.ovf_o      = ovf_q;

endmodule
